// File: rtl/iterative_multiplication.sv
// Signed WIDTH x WIDTH shift-and-add multiplier with valid/ready operand and result channels.
// Operands are captured independently; the product appears exactly WIDTH cycles after the last one.
module iterative_multiplication #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   iterative_multiplication__lhs,
  input  logic               iterative_multiplication__lhs_vld,
  output logic               iterative_multiplication__lhs_rdy,
  input  logic [WIDTH-1:0]   iterative_multiplication__rhs,
  input  logic               iterative_multiplication__rhs_vld,
  output logic               iterative_multiplication__rhs_rdy,
  output logic [2*WIDTH-1:0] iterative_multiplication__result,
  output logic               iterative_multiplication__result_vld,
  input  logic               iterative_multiplication__result_rdy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic               lhs_held, rhs_held;
  logic [WIDTH-1:0]   lhs_q, rhs_q;
  logic [WIDTH-1:0]   mag_lhs, mag_rhs;
  logic               sign;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] result_q;
  logic               result_vld_q;

  logic               lhs_fire, rhs_fire, operands_ready;
  logic [WIDTH-1:0]   lhs_cur, rhs_cur;

  // Two's-complement magnitude as unsigned; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  assign iterative_multiplication__lhs_rdy    = (state == IDLE) & ~lhs_held;
  assign iterative_multiplication__rhs_rdy    = (state == IDLE) & ~rhs_held;
  assign iterative_multiplication__result     = result_q;
  assign iterative_multiplication__result_vld = result_vld_q;

  assign lhs_fire = iterative_multiplication__lhs_vld & iterative_multiplication__lhs_rdy;
  assign rhs_fire = iterative_multiplication__rhs_vld & iterative_multiplication__rhs_rdy;
  assign lhs_cur  = lhs_held ? lhs_q : iterative_multiplication__lhs;
  assign rhs_cur  = rhs_held ? rhs_q : iterative_multiplication__rhs;
  assign operands_ready = (state == IDLE) & (lhs_held | lhs_fire) & (rhs_held | rhs_fire);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    acc_next = acc;
    if (mag_rhs[cnt])
      acc_next = acc + ({{WIDTH{1'b0}}, mag_lhs} << cnt);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      lhs_held     <= 1'b0;
      rhs_held     <= 1'b0;
      lhs_q        <= '0;
      rhs_q        <= '0;
      mag_lhs      <= '0;
      mag_rhs      <= '0;
      sign         <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (operands_ready) begin
            mag_lhs  <= magnitude(lhs_cur);
            mag_rhs  <= magnitude(rhs_cur);
            sign     <= lhs_cur[WIDTH-1] ^ rhs_cur[WIDTH-1];
            acc      <= '0;
            cnt      <= '0;
            lhs_held <= 1'b0;
            rhs_held <= 1'b0;
            state    <= RUN;
          end else begin
            if (lhs_fire) begin
              lhs_held <= 1'b1;
              lhs_q    <= iterative_multiplication__lhs;
            end
            if (rhs_fire) begin
              rhs_held <= 1'b1;
              rhs_q    <= iterative_multiplication__rhs;
            end
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            // Negating a zero accumulator yields zero, so a signed zero operand is harmless.
            result_q     <= sign ? (~acc_next + 1'b1) : acc_next;
            result_vld_q <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (iterative_multiplication__result_rdy) begin
            result_vld_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_multiplication.sv
// Self-checking bench for iterative_multiplication: directed corner cases plus randomized
// operands, arrival skews and result back-pressure, checked against plain integer multiplication.
module tb_iterative_multiplication;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   lhs, rhs;
  logic               lhs_vld, rhs_vld, result_rdy;
  logic               lhs_rdy, rhs_rdy, result_vld;
  logic [2*WIDTH-1:0] result;

  int vectors     = 0;
  int miscompares = 0;

  iterative_multiplication #(.WIDTH(WIDTH)) dut (
    .clk                                  (clk),
    .rst                                  (rst),
    .iterative_multiplication__lhs        (lhs),
    .iterative_multiplication__lhs_vld    (lhs_vld),
    .iterative_multiplication__lhs_rdy    (lhs_rdy),
    .iterative_multiplication__rhs        (rhs),
    .iterative_multiplication__rhs_vld    (rhs_vld),
    .iterative_multiplication__rhs_rdy    (rhs_rdy),
    .iterative_multiplication__result     (result),
    .iterative_multiplication__result_vld (result_vld),
    .iterative_multiplication__result_rdy (result_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the signed product of the two operands, truncated to 2*WIDTH bits.
  function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int pa, pb;
    pa = $signed(a);
    pb = $signed(b);
    return (2*WIDTH)'(pa * pb);
  endfunction

  // One full transaction. Called at a negedge; returns at a negedge with the channel back in IDLE.
  // lhs_lag/rhs_lag: cycle at which each operand is first offered; stall: DONE cycles with result_rdy low.
  task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                    input int lhs_lag, input int rhs_lag, input int stall);
    logic [2*WIDTH-1:0] exp;
    bit ld, rd, lf, rf;
    int cyc;
    exp = model(a, b);
    ld  = 0;
    rd  = 0;
    cyc = 0;
    result_rdy = (stall == 0);
    while (!(ld && rd) && cyc < 20) begin
      check("lhs_rdy_idle", lhs_rdy, !ld);
      check("rhs_rdy_idle", rhs_rdy, !rd);
      // Once an operand is held, keep pulsing junk on its channel; it must be ignored.
      if (!ld) begin lhs_vld = (cyc >= lhs_lag); lhs = a; end
      else     begin lhs_vld = 1'($urandom_range(0, 1)); lhs = WIDTH'($urandom); end
      if (!rd) begin rhs_vld = (cyc >= rhs_lag); rhs = b; end
      else     begin rhs_vld = 1'($urandom_range(0, 1)); rhs = WIDTH'($urandom); end
      lf = lhs_vld & lhs_rdy;
      rf = rhs_vld & rhs_rdy;
      @(negedge clk);
      ld = ld | lf;
      rd = rd | rf;
      cyc++;
    end
    if (!(ld && rd)) begin
      check("accept_timeout", 32'd0, 32'd1);
      lhs_vld = 0;
      rhs_vld = 0;
      return;
    end
    for (int k = 0; k < WIDTH; k++) begin
      check("vld_early", result_vld, 1'b0);
      check("lhs_rdy_run", lhs_rdy, 1'b0);
      check("rhs_rdy_run", rhs_rdy, 1'b0);
      lhs_vld = 1'($urandom_range(0, 1)); lhs = WIDTH'($urandom);
      rhs_vld = 1'($urandom_range(0, 1)); rhs = WIDTH'($urandom);
      @(negedge clk);
    end
    lhs_vld = 0;
    rhs_vld = 0;
    check("vld_latency", result_vld, 1'b1);
    check("result", result, exp);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("vld_stall", result_vld, 1'b1);
      check("result_stall", result, exp);
      check("lhs_rdy_done", lhs_rdy, 1'b0);
      check("rhs_rdy_done", rhs_rdy, 1'b0);
    end
    result_rdy = 1;
    @(negedge clk);
    check("vld_cleared", result_vld, 1'b0);
    check("result_held", result, exp);
    check("lhs_rdy_back", lhs_rdy, 1'b1);
    check("rhs_rdy_back", rhs_rdy, 1'b1);
    result_rdy = 0;
  endtask

  logic [WIDTH-1:0] ra, rb;

  initial begin
    rst = 0; lhs = '0; rhs = '0; lhs_vld = 0; rhs_vld = 0; result_rdy = 0;
    #1;
    check("rst_result", result, 16'h0000);
    check("rst_vld", result_vld, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1;
    check("rst_lhs_rdy", lhs_rdy, 1'b1);
    check("rst_rhs_rdy", rhs_rdy, 1'b1);

    op(8'h07, 8'hFD, 0, 0, 0);   // 7 * -3 = 0xFFEB
    op(8'h80, 8'h80, 0, 0, 1);   // -128 * -128 = 0x4000
    op(8'h80, 8'h7F, 1, 0, 0);   // -128 * 127 = 0xC080
    op(8'h00, 8'hFB, 0, 2, 0);   // 0 * -5 = 0
    op(8'h01, 8'hFF, 0, 0, 0);   // 1 * -1 = 0xFFFF
    op(8'h06, 8'h05, 3, 0, 0);   // rhs first, lhs offered at cycle 3
    op(8'hF7, 8'h00, 2, 1, 10);  // -9 * 0 with a long DONE stall

    // Asynchronous reset in the middle of RUN (counter at 4): operation abandoned.
    lhs = 8'h64; rhs = 8'hF9; lhs_vld = 1; rhs_vld = 1; result_rdy = 1;
    @(negedge clk);
    lhs_vld = 0; rhs_vld = 0;
    repeat (4) @(negedge clk);
    #2 rst = 0;
    #1;
    check("arst_result", result, 16'h0000);
    check("arst_vld", result_vld, 1'b0);
    check("arst_lhs_rdy", lhs_rdy, 1'b1);
    check("arst_rhs_rdy", rhs_rdy, 1'b1);
    @(negedge clk);
    rst = 1;
    for (int k = 0; k < WIDTH + 2; k++) begin
      @(negedge clk);
      check("arst_no_result", result_vld, 1'b0);
    end
    result_rdy = 0;
    op(8'h03, 8'h04, 0, 0, 0);   // 3 * 4 = 12

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0:       ra = 8'h80;
        1:       ra = 8'h00;
        default: ra = WIDTH'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0:       rb = 8'h80;
        1:       rb = 8'hFF;
        default: rb = WIDTH'($urandom);
      endcase
      op(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
